seq_alu: RTL and testbench

- Parametrised, handshaked successor to the processor's 16-bit combinational ALU.
- Single-cycle ops: AND, OR, ADD, SUB, XOR, SLT.
- Multi-cycle ops: MUL, SHL, SHR, SRA. Multiply is shift-add; shifts move one bit per cycle.
- Produces registered result plus zero, negative, carry and overflow flags. Sits between decode/register-read and writeback; stalls the pipeline through ready/valid.

---
 rtl/seq_alu.sv | 189 ++++++++++++++++++
 tb/tb_seq_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and bit-serial shifts, with registered result and flags.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_SHL, K_SHR, K_SRA} kind_t;

    state_t             state;
    kind_t              kind;
    logic [SHW:0]       cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   md;
    logic [WIDTH-1:0]   sh;

    logic               accept;
    logic               finish;
    logic               last_iter;
    logic               is_mul;
    logic               is_shift;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;
    logic               slt;
    logic [WIDTH-1:0]   fin_y;
    logic               fin_c;
    logic               fin_v;
    logic               fin_ill;

    // NOTE: in_ready is combinational on out_ready so a result can be consumed
    // and a new op accepted on the same edge without a bubble.
    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];
    assign is_mul    = (alu_op == OP_MUL);
    assign is_shift  = (alu_op inside {OP_SHL, OP_SHR, OP_SRA}) && (shamt != '0);
    assign last_iter = (cnt == (SHW+1)'(1));
    assign finish    = ((state == S_BUSY) && last_iter) || (accept && !is_mul && !is_shift);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        add_w    = {1'b0, a} + {1'b0, b};
        sub_w    = {1'b0, a} - {1'b0, b};
        slt      = $signed(a) < $signed(b);
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, md} : '0);
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        sh_next  = sh;
        sh_out   = 1'b0;
        case (kind)
            K_SHL: begin sh_next = {sh[WIDTH-2:0], 1'b0};      sh_out = sh[WIDTH-1]; end
            K_SHR: begin sh_next = {1'b0, sh[WIDTH-1:1]};      sh_out = sh[0];       end
            K_SRA: begin sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_out = sh[0];     end
            default: ;
        endcase
    end

    // Result selection: iterative datapath while busy, otherwise the live operands.
    always_comb begin
        fin_y   = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_ill = 1'b0;
        if (state == S_BUSY) begin
            if (kind == K_MUL) begin
                fin_y = acc_next[WIDTH-1:0];
                fin_c = |acc_next[2*WIDTH-1:WIDTH];
            end else begin
                fin_y = sh_next;
                fin_c = sh_out;
            end
        end else begin
            case (alu_op)
                OP_AND: fin_y = a & b;
                OP_OR:  fin_y = a | b;
                OP_XOR: fin_y = a ^ b;
                OP_ADD: begin
                    fin_y = add_w[WIDTH-1:0];
                    fin_c = add_w[WIDTH];
                    fin_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    fin_y = sub_w[WIDTH-1:0];
                    fin_c = sub_w[WIDTH];
                    fin_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SLT: fin_y = {{(WIDTH-1){1'b0}}, slt};
                OP_SHL, OP_SHR, OP_SRA: fin_y = a;
                OP_MUL: fin_y = '0;
                default: fin_ill = 1'b1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so an aborted op leaves no residue.
            state      <= S_IDLE;
            kind       <= K_MUL;
            cnt        <= '0;
            acc        <= '0;
            md         <= '0;
            sh         <= '0;
            y          <= '0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                S_BUSY: begin
                    if (kind == K_MUL) acc <= acc_next;
                    else               sh  <= sh_next;
                    cnt <= cnt - 1'b1;
                    if (last_iter) state <= S_DONE;
                end
                default: begin
                    if (accept) begin
                        if (is_mul) begin
                            acc   <= {{WIDTH{1'b0}}, b};
                            md    <= a;
                            cnt   <= (SHW+1)'(WIDTH);
                            kind  <= K_MUL;
                            state <= S_BUSY;
                        end else if (is_shift) begin
                            sh    <= a;
                            cnt   <= {1'b0, shamt};
                            kind  <= (alu_op == OP_SHL) ? K_SHL :
                                     (alu_op == OP_SHR) ? K_SHR : K_SRA;
                            state <= S_BUSY;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase

            if (finish) begin
                y          <= fin_y;
                zero       <= (fin_y == '0);
                negative   <= fin_y[WIDTH-1];
                carry      <= fin_c;
                overflow   <= fin_v;
                illegal_op <= fin_ill;
                out_valid  <= 1'b1;
            end else if (accept || ((state == S_DONE) && out_ready)) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vectors plus random ops checked
// against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         z, n, c, v, ill;
        int           lat;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [3:0] op);
        exp_t    e;
        int      k;
        int      sa, sb, r;
        longint  p;
        e.y = '0; e.c = 0; e.v = 0; e.ill = 0; e.lat = 1;
        k  = int'(mb[3:0]);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        case (op)
            4'b0000: e.y = ma & mb;
            4'b0001: e.y = ma | mb;
            4'b0011: e.y = ma ^ mb;
            4'b0010: begin
                r   = int'(ma) + int'(mb);
                e.y = W'(r);
                e.c = r > 65535;
                e.v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'b0110: begin
                e.y = ma - mb;
                e.c = ma < mb;
                e.v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'b0111: e.y = (sa < sb) ? W'(1) : W'(0);
            4'b1000: begin
                p     = longint'(ma) * longint'(mb);
                e.y   = W'(p);
                e.c   = p > 65535;
                e.lat = W + 1;
            end
            4'b1001: begin
                e.y   = ma << k;
                e.c   = (k > 0) && (((int'(ma) >> (W - k)) & 1) != 0);
                e.lat = k + 1;
            end
            4'b1010: begin
                e.y   = ma >> k;
                e.c   = (k > 0) && (((int'(ma) >> (k - 1)) & 1) != 0);
                e.lat = k + 1;
            end
            4'b1011: begin
                e.y   = $signed(ma) >>> k;
                e.c   = (k > 0) && (((int'(ma) >> (k - 1)) & 1) != 0);
                e.lat = k + 1;
            end
            default: e.ill = 1;
        endcase
        e.z = (e.y == '0);
        e.n = e.y[W-1];
        return e;
    endfunction

    // Presents one op, measures latency, checks result/flags, optionally stalls.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] op,
                         input int stall, input bit no_bubble, output logic [W-1:0] got_y);
        exp_t e;
        int   wait_n;
        int   lat;
        bit   busy_ready;
        e = model(ta, tb_v, op);
        in_valid = 1'b1; a = ta; b = tb_v; alu_op = op;
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("accept_wait", 32'(wait_n < 100), 1);
        if (no_bubble) check("no_bubble", wait_n, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        alu_op    = 4'($urandom);
        out_ready = (stall == 0);
        lat = 1;
        busy_ready = 0;
        while (!out_valid && lat < 100) begin
            busy_ready |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, e.lat);
        check("y", y, e.y);
        check("flags", {zero, negative, carry, overflow, illegal_op}, {e.z, e.n, e.c, e.v, e.ill});
        if (e.lat > 1) check("busy_in_ready", busy_ready, 0);
        got_y = y;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {out_valid, in_ready, y}, {1'b1, 1'b0, e.y});
        end
        if (stall > 0) begin
            out_ready = 1'b1;
            #1;
            check("consume_ready", in_ready, 1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] r;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out", {out_valid, y, zero, negative, carry, overflow, illegal_op}, 0);
        check("reset_ready", in_ready, 1);

        do_op(16'h7FFF, 16'h0001, 4'b0010, 0, 0, r);
        check("add_ovf_y", r, 16'h8000);

        do_op(16'h0005, 16'h0005, 4'b0110, 0, 0, r);
        check("sub_zero_y", r, 16'h0000);
        do_op(16'h0003, 16'h0005, 4'b0110, 0, 1, r);
        check("sub_borrow_y", r, 16'hFFFE);

        do_op(16'h012C, 16'h012C, 4'b1000, 0, 1, r);
        check("mul_y", r, 16'h5F90);

        do_op(16'h0001, 16'h000F, 4'b1001, 0, 1, r);
        check("shl15_y", r, 16'h8000);
        do_op(16'h8000, 16'h0004, 4'b1011, 0, 1, r);
        check("sra4_y", r, 16'hF800);
        do_op(16'h1234, 16'h00F0, 4'b1010, 0, 1, r);
        check("shr0_y", r, 16'h1234);

        do_op(16'h0001, 16'h0002, 4'b0010, 5, 0, r);
        check("bp_y", r, 16'h0003);
        @(posedge clk); #1;
        check("bp_idle", {out_valid, in_ready}, 2'b01);

        do_op(16'hABCD, 16'h1234, 4'b0101, 0, 0, r);
        check("illegal_flag", illegal_op, 1);
        do_op(16'h00F0, 16'h0F00, 4'b0001, 0, 1, r);
        check("illegal_cleared", illegal_op, 0);

        // Reset in the middle of a multiply.
        in_valid = 1'b1; a = 16'h1234; b = 16'h5678; alu_op = 4'b1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out", {out_valid, y, zero, negative, carry, overflow, illegal_op}, 0);
        check("abort_ready", in_ready, 1);
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        check("abort_no_pulse", out_valid, 0);
        do_op(16'h0002, 16'h0002, 4'b0010, 0, 0, r);
        check("post_abort_y", r, 16'h0004);

        for (int i = 0; i < 60; i++) begin
            do_op(W'($urandom), W'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 0, r);
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
